// File: rtl/vscale_dmem_responder_pkg.sv
// Shared definitions for the vscale data-memory responder: HASTI size codes,
// FSM state encoding, wait-counter width and the access-check helpers.
package vscale_dmem_responder_pkg;

    localparam int MEM_TYPE_WIDTH = 3;
    localparam logic [MEM_TYPE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Misaligned for its size, unsupported size, or beyond the array.
    function automatic logic access_bad(input logic [MEM_TYPE_WIDTH-1:0] size,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic align_bad_s;
        case (size)
            HASTI_SIZE_BYTE: align_bad_s = 1'b0;
            HASTI_SIZE_HALF: align_bad_s = addr[0];
            HASTI_SIZE_WORD: align_bad_s = (addr[1:0] != 2'b00);
            default:         align_bad_s = 1'b1;
        endcase
        return align_bad_s || (addr >= limit);
    endfunction

    function automatic logic [3:0] byte_strobe(input logic [MEM_TYPE_WIDTH-1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] strb_s;
        case (size)
            HASTI_SIZE_BYTE: strb_s = 4'b0001 << addr_lo;
            HASTI_SIZE_HALF: strb_s = 4'b0011 << addr_lo;
            HASTI_SIZE_WORD: strb_s = 4'b1111;
            default:         strb_s = 4'b0000;
        endcase
        return strb_s;
    endfunction

endpackage

// File: rtl/vscale_dmem_array.sv
// Synchronous-read word RAM with four independently strobed byte lanes.
// Contents are deliberately not reset.
module vscale_dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata,
    input  logic                  wen,
    input  logic [3:0]            wstrb,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata
);

    logic [31:0] mem_r [0:DEPTH_WORDS-1];

    // Byte-lane write port
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port; a same-edge write is not visible to the read
    always_ff @(posedge clk) begin
        if (ren) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Terminates a vscale dmem port: accepts address phases, counts wait states,
// completes byte-strobed writes / word reads and flags bad accesses.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [31:0]               dmem_addr,
    input  logic [31:0]               dmem_wdata_delayed,
    output logic [31:0]               dmem_rdata,
    output logic                      dmem_wait,
    output logic                      dmem_badmem_e
);

    localparam int ADDR_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE  = {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ZERO = {WAIT_CNT_WIDTH{1'b0}};
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    dmem_state_e               state_r, state_nxt_s;
    logic [WAIT_CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic                      accept_s, in_bad_s;
    logic                      wen_r, bad_r;
    logic [MEM_TYPE_WIDTH-1:0] size_r;
    logic [ADDR_WIDTH+1:0]     addr_r;
    logic                      ren_s, wr_s, hazard_s;
    logic [ADDR_WIDTH-1:0]     raddr_s, waddr_s;
    logic [3:0]                wstrb_s;
    logic                      rd_valid_r, byp_valid_r;
    logic [3:0]                byp_strb_r;
    logic [31:0]               byp_data_r, arr_rdata_s, merged_s;

    assign dmem_wait     = (state_r == DMEM_WAIT);
    assign dmem_badmem_e = (state_r == DMEM_RESP) && bad_r;
    assign dmem_rdata    = (rd_valid_r && !bad_r) ? merged_s : 32'h0000_0000;
    assign accept_s      = dmem_en && !dmem_wait;
    assign in_bad_s      = access_bad(dmem_size, dmem_addr, ADDR_LIMIT);

    // Next-state and wait-counter logic; RESP may accept the next request directly
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            DMEM_IDLE, DMEM_RESP: begin
                if (accept_s) begin
                    if (ZERO_WAIT) begin
                        state_nxt_s = DMEM_RESP;
                    end else begin
                        state_nxt_s = DMEM_WAIT;
                    end
                    cnt_nxt_s = WAIT_LOAD;
                end else begin
                    state_nxt_s = DMEM_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            DMEM_WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = DMEM_RESP;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = DMEM_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = DMEM_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and the latched address-phase fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= DMEM_IDLE;
            cnt_r   <= CNT_ZERO;
            wen_r   <= 1'b0;
            bad_r   <= 1'b0;
            size_r  <= HASTI_SIZE_BYTE;
            addr_r  <= {(ADDR_WIDTH+2){1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                wen_r  <= dmem_wen;
                bad_r  <= in_bad_s;
                size_r <= dmem_size;
                addr_r <= dmem_addr[ADDR_WIDTH+1:0];
            end
        end
    end

    // Array control: read lands in the cycle before RESP so data is ready in RESP
    always_comb begin
        wr_s    = (state_r == DMEM_RESP) && wen_r && !bad_r;
        wstrb_s = byte_strobe(size_r, addr_r[1:0]);
        waddr_s = addr_r[ADDR_WIDTH+1:2];
        if (ZERO_WAIT) begin
            ren_s   = accept_s && !dmem_wen && !in_bad_s;
            raddr_s = dmem_addr[ADDR_WIDTH+1:2];
        end else begin
            ren_s   = (state_r == DMEM_WAIT) && (cnt_r == CNT_ONE) && !wen_r && !bad_r;
            raddr_s = addr_r[ADDR_WIDTH+1:2];
        end
        hazard_s = wr_s && ren_s && (raddr_s == waddr_s);
    end

    // Overlay bytes of a write that retired on the same edge the read was issued
    always_comb begin
        merged_s = arr_rdata_s;
        for (int i = 0; i < 4; i++) begin
            if (byp_valid_r && byp_strb_r[i]) begin
                merged_s[8*i +: 8] = byp_data_r[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = arr_rdata_s[8*i +: 8];
            end
        end
    end

    // Read-valid tracking and bypass capture, refreshed on every array read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r  <= 1'b0;
            byp_valid_r <= 1'b0;
            byp_strb_r  <= 4'b0000;
            byp_data_r  <= 32'h0000_0000;
        end else if (ren_s) begin
            rd_valid_r  <= 1'b1;
            byp_valid_r <= hazard_s;
            byp_strb_r  <= wstrb_s;
            byp_data_r  <= dmem_wdata_delayed;
        end
    end

    vscale_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .ren  (ren_s),
        .raddr(raddr_s),
        .rdata(arr_rdata_s),
        .wen  (wr_s),
        .wstrb(wstrb_s),
        .waddr(waddr_s),
        .wdata(dmem_wdata_delayed)
    );

endmodule
